// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus.
// Carries the redirect inputs from control/decode into pc_gen and the
// registered fetch address/enable back out to instruction memory.
//   master : pc_gen side (receives stall/flush/branch, drives pc/ce/status)
//   slave  : control/decode/imem side (mirror of master)
// Optional macro PC_ALIGN_CHECK_EN adds the misalign status signal.
interface pc_gen_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;
    logic               branch_flag;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               redirect_pending;
`ifdef PC_ALIGN_CHECK_EN
    logic               misalign;
`endif

    modport master (
        input  stall,
        input  flush,
        input  new_pc,
        input  branch_flag,
        input  branch_target,
        output pc,
        output ce,
        output redirect_pending
`ifdef PC_ALIGN_CHECK_EN
        ,
        output misalign
`endif
    );

    modport slave (
        output stall,
        output flush,
        output new_pc,
        output branch_flag,
        output branch_target,
        input  pc,
        input  ce,
        input  redirect_pending
`ifdef PC_ALIGN_CHECK_EN
        ,
        input  misalign
`endif
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Produces the registered instruction fetch address and memory enable,
// honouring flush, stall and branch redirects. A branch seen while stalled
// is parked in a pending-target register and applied once the stall clears.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - pc_gen_if.master: stall/flush/new_pc/branch_flag/branch_target in,
//          pc/ce/redirect_pending (and misalign) out, all outputs registered
// Optional macro PC_ALIGN_CHECK_EN: adds the registered misalign flag.
module pc_gen #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
    parameter int unsigned          INC       = 4,
    parameter int unsigned          STALL_W   = 6
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_tgt;
    logic               r_ce;
    logic               r_pend;

    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [ADDR_W-1:0]  w_tgt_nxt;
    logic               w_ce_nxt;
    logic               w_pend_nxt;
    logic               w_stall;

    // Only stall bit 0 freezes the PC; the upper bits are for other stages.
    assign w_stall = bus.stall[0];

    generate
        if (STALL_W > 1) begin : g_stall_hi
            logic w_stall_hi_unused;
            assign w_stall_hi_unused = ^bus.stall[STALL_W-1:1];
        end
    endgenerate

    // Next-state / next-PC selection in redirect priority order.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;

        case (r_state)
            ST_OFF: begin
                w_state_nxt = ST_RUN;
                w_pc_nxt    = RESET_VEC;
            end
            default: begin
                if (bus.flush) begin
                    // Flush wins over everything and drops any parked branch.
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = bus.new_pc;
                    w_tgt_nxt   = '0;
                end else if (!w_stall) begin
                    w_state_nxt = ST_RUN;
                    if (bus.branch_flag) begin
                        w_pc_nxt = bus.branch_target;
                    end else if (r_state == ST_HELD) begin
                        w_pc_nxt = r_tgt;
                    end else begin
                        w_pc_nxt = r_pc + ADDR_W'(INC);
                    end
                end else if (bus.branch_flag) begin
                    // Stalled branch: park it; newest one wins.
                    w_state_nxt = ST_HELD;
                    w_tgt_nxt   = bus.branch_target;
                end
            end
        endcase

        w_ce_nxt   = (w_state_nxt != ST_OFF);
        w_pend_nxt = (w_state_nxt == ST_HELD);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_pc    <= RESET_VEC;
            r_tgt   <= '0;
            r_ce    <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
            r_ce    <= w_ce_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    assign bus.pc               = r_pc;
    assign bus.ce               = r_ce;
    assign bus.redirect_pending = r_pend;

`ifdef PC_ALIGN_CHECK_EN
    // Low log2(INC) bits of the next PC must be zero; mask is empty for INC=1.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

    logic r_misalign;
    logic w_misalign_nxt;

    assign w_misalign_nxt = |(w_pc_nxt & ALIGN_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end

    assign bus.misalign = r_misalign;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: reset release, sequential fetch,
// 8-bit wrap, stalled branch, flush priority, live-vs-pending branch,
// ignored upper stall bits, async reset mid-stall, optional misalign.
module tb_pc_gen;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus_a ();
    pc_gen_if #(.ADDR_W(8),  .STALL_W(6)) bus_b ();

    pc_gen #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0000_0100),
        .INC       (4),
        .STALL_W   (6)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pc_gen #(
        .ADDR_W    (8),
        .RESET_VEC (8'hF8),
        .INC       (4),
        .STALL_W   (6)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus_a.stall = '0; bus_a.flush = 1'b0; bus_a.new_pc = '0;
        bus_a.branch_flag = 1'b0; bus_a.branch_target = '0;
        bus_b.stall = '0; bus_b.flush = 1'b0; bus_b.new_pc = '0;
        bus_b.branch_flag = 1'b0; bus_b.branch_target = '0;

        step();
        step();
        chk("rst_ce", 32'(bus_a.ce), 32'h0);
        chk("rst_pc", bus_a.pc, 32'h100);
        chk("rst_pend", 32'(bus_a.redirect_pending), 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("rst_mis", 32'(bus_a.misalign), 32'h0);
`endif

        rst = 1'b0;
        step();
        chk("e1_ce", 32'(bus_a.ce), 32'h1);
        chk("e1_pc", bus_a.pc, 32'h100);
        chk("b_e1_pc", 32'(bus_b.pc), 32'hF8);
        step();
        chk("e2_pc", bus_a.pc, 32'h104);
        chk("b_e2_pc", 32'(bus_b.pc), 32'hFC);
        step();
        chk("e3_pc", bus_a.pc, 32'h108);
        chk("b_wrap_pc", 32'(bus_b.pc), 32'h00);
        chk("b_wrap_ce", 32'(bus_b.ce), 32'h1);

        // Branch arrives while stalled, stall held 3 cycles.
        bus_a.stall = 6'd1; bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h40;
        step();
        chk("st1_pc", bus_a.pc, 32'h108);
        chk("st1_pend", 32'(bus_a.redirect_pending), 32'h1);
        bus_a.branch_flag = 1'b0; bus_a.branch_target = 32'h0;
        step();
        chk("st2_pc", bus_a.pc, 32'h108);
        chk("st2_pend", 32'(bus_a.redirect_pending), 32'h1);
        step();
        chk("st3_pc", bus_a.pc, 32'h108);
        chk("st3_pend", 32'(bus_a.redirect_pending), 32'h1);
        bus_a.stall = 6'd0;
        step();
        chk("rel_pc", bus_a.pc, 32'h40);
        chk("rel_pend", 32'(bus_a.redirect_pending), 32'h0);
        step();
        chk("rel_seq", bus_a.pc, 32'h44);

        // Flush while HELD and still stalled discards the parked branch.
        bus_a.stall = 6'd1; bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h40;
        step();
        chk("h2_pend", 32'(bus_a.redirect_pending), 32'h1);
        chk("h2_pc", bus_a.pc, 32'h44);
        bus_a.branch_flag = 1'b0; bus_a.flush = 1'b1; bus_a.new_pc = 32'h80;
        step();
        chk("fl_pc", bus_a.pc, 32'h80);
        chk("fl_pend", 32'(bus_a.redirect_pending), 32'h0);
        bus_a.flush = 1'b0;
        step();
        chk("fl_hold", bus_a.pc, 32'h80);
        bus_a.stall = 6'd0;
        step();
        chk("fl_seq", bus_a.pc, 32'h84);

        // Flush and branch on the same edge: flush wins.
        bus_a.flush = 1'b1; bus_a.new_pc = 32'h200;
        bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h300;
        step();
        chk("fb_pc", bus_a.pc, 32'h200);
        bus_a.flush = 1'b0; bus_a.branch_flag = 1'b0;
        step();
        chk("fb_seq", bus_a.pc, 32'h204);

        // Live branch beats a pending one.
        bus_a.stall = 6'd1; bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h40;
        step();
        chk("lb_hold", bus_a.pc, 32'h204);
        chk("lb_pend", 32'(bus_a.redirect_pending), 32'h1);
        bus_a.stall = 6'd0; bus_a.branch_target = 32'h60;
        step();
        chk("lb_pc", bus_a.pc, 32'h60);
        chk("lb_pend0", 32'(bus_a.redirect_pending), 32'h0);
        bus_a.branch_flag = 1'b0;
        step();
        chk("lb_seq", bus_a.pc, 32'h64);

        // Upper stall bits do not freeze the PC.
        bus_a.stall = 6'b111110;
        step();
        chk("hi_stall", bus_a.pc, 32'h68);
        bus_a.stall = 6'd0;

        // Misaligned branch target is loaded unmodified.
        bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h42;
        step();
        chk("ma_pc", bus_a.pc, 32'h42);
`ifdef PC_ALIGN_CHECK_EN
        chk("ma_mis", 32'(bus_a.misalign), 32'h1);
`endif
        bus_a.branch_flag = 1'b0;
        step();
        chk("ma_seq", bus_a.pc, 32'h46);
`ifdef PC_ALIGN_CHECK_EN
        chk("ma_mis2", 32'(bus_a.misalign), 32'h1);
`endif

        // Async reset pulsed mid-stall while HELD.
        bus_a.stall = 6'd1; bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h10;
        step();
        chk("ar_pend", 32'(bus_a.redirect_pending), 32'h1);
        bus_a.branch_flag = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_ce", 32'(bus_a.ce), 32'h0);
        chk("ar_pc", bus_a.pc, 32'h100);
        chk("ar_pend0", 32'(bus_a.redirect_pending), 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("ar_mis", 32'(bus_a.misalign), 32'h0);
`endif
        step();
        rst = 1'b0;
        step();
        chk("ar_e1_ce", 32'(bus_a.ce), 32'h1);
        chk("ar_e1_pc", bus_a.pc, 32'h100);
        step();
        chk("ar_stall_pc", bus_a.pc, 32'h100);
        chk("ar_stall_pend", 32'(bus_a.redirect_pending), 32'h0);
        bus_a.stall = 6'd0;
        step();
        chk("ar_seq", bus_a.pc, 32'h104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, replacing the fixed 32-bit PC register. It drives the instruction-memory address `pc` and enable `ce` from a configurable reset vector. It accepts pipeline stall, flush-with-new-PC (exception entry/return) and branch redirects. A branch that arrives while fetch is stalled is held in a pending-redirect register, so no redirect is lost. It sits between the control unit (stall/flush), the decode/execute stage (branch) and the instruction-memory interface.

## Interface
- `ADDR_W`, 32 — PC width in bits.
- `RESET_VEC`, 0 — PC value held in reset and while `ce` is low.
- `INC`, 4 — sequential increment, power of two ≥ 1.
- `STALL_W`, 6 — stall vector width; only bit 0 is used here.

- `clk`  in  1  — sole clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `stall`  in  STALL_W  — stall vector from control; `stall[0]`=1 freezes the PC.
- `flush`  in  1  — exception/flush redirect, overrides stall.
- `new_pc`  in  ADDR_W  — flush target, sampled when `flush`=1.
- `branch_flag`  in  1  — branch/jump taken.
- `branch_target`  in  ADDR_W  — branch target, sampled when `branch_flag`=1.
- `pc`  out  ADDR_W  — registered fetch address.
- `ce`  out  1  — registered instruction-memory enable.
- `redirect_pending`  out  1  — registered; a stalled branch is waiting.
- `misalign`  out  1  — registered; present only with `PC_ALIGN_CHECK_EN`.

## Operation
- States: OFF (`ce`=0), RUN, HELD (RUN plus a stored pending branch). `redirect_pending` equals (state==HELD).
- Reset (async, any time): `ce`=0, `pc`=RESET_VEC, `redirect_pending`=0, pending target=0, `misalign`=0. State goes to OFF.
- OFF: `ce` goes to 1 on the first edge after `rst` falls. `pc` holds RESET_VEC on that edge. All redirect inputs are ignored while `ce`=0.
- RUN/HELD next-PC priority, evaluated each edge with `ce`=1:
  1. `flush`=1 → `pc`=`new_pc`. Any pending branch is discarded and state goes to RUN. This applies regardless of `stall[0]` and `branch_flag`.
  2. `stall[0]`=0 and `branch_flag`=1 → `pc`=`branch_target`, state goes to RUN. A live branch beats an older pending one.
  3. `stall[0]`=0 and HELD → `pc`=stored target, state goes to RUN.
  4. `stall[0]`=0 → `pc`=`pc`+INC. Wraps modulo 2^ADDR_W; the carry is discarded.
  5. `stall[0]`=1 and `branch_flag`=1 → `pc` holds. `branch_target` is stored and state goes to HELD. A newer branch overwrites an older stored one.
  6. `stall[0]`=1 otherwise → `pc` and state hold.
- `stall[STALL_W-1:1]` is ignored.

## Timing
- All outputs are registered. No combinational input-to-output path exists.
- Redirect latency is 1 cycle: an input sampled at edge N appears on `pc` after edge N.
- A stalled branch takes effect on the first edge with `stall[0]`=0 and `flush`=0.
- After `rst` deasserts, the sequence is: edge 1 gives `ce`=1, `pc`=RESET_VEC; edge 2 gives `pc`=RESET_VEC+INC (no stall).
- If reset asserts mid-stall or while HELD, the pending redirect is lost and the block restarts from OFF.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - Port `misalign` exists.
  - It is registered alongside `pc` and is 1 when the low log2(INC) bits of the next `pc` are nonzero.
  - `pc` is still loaded unmodified; control decides how to handle the fault.
  - When INC=1 it is constantly 0.
- Not defined: port `misalign` and its logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset release, RESET_VEC=0x100, INC=4, no stall → `ce` 0→1 on edge 1; `pc` reads 0x100, 0x104, 0x108 on the following edges.
- ADDR_W=8, `pc`=0xFC, INC=4 → next `pc`=0x00 (wrap); `ce` stays 1.
- `stall[0]`=1 for 3 cycles with `branch_flag`=1/`branch_target`=0x40 on the first of them → `pc` frozen and `redirect_pending`=1 for 3 cycles; on release `pc`=0x40 and `redirect_pending`=0.
- While HELD (target 0x40), `flush`=1, `new_pc`=0x80, stall still high → `pc`=0x80 next edge, `redirect_pending`=0, 0x40 is never fetched.
- Same edge `flush`=1 (`new_pc`=0x200) and `branch_flag`=1 (0x300), no stall → `pc`=0x200. Separately, in HELD (0x40) with a live branch to 0x60 and no stall → `pc`=0x60.
- With `PC_ALIGN_CHECK_EN`: branch to 0x42 with INC=4 → `pc`=0x42 and `misalign`=1 on the same edge; the next sequential PC 0x46 keeps `misalign`=1. Async `rst` pulsed mid-stall → `ce`=0, `pc`=RESET_VEC and `misalign`=0 immediately, without waiting for a clock edge.
